// File: rtl/bp_update_sched.sv
// Branch predictor update scheduler.
// Collects up to two in-order branch commits per cycle into a small FIFO and
// issues at most one predictor update per cycle. After a mispredict update a
// configurable number of idle cycles is inserted so history repair settles
// before the next update is presented.
module bp_update_sched #(
  parameter int DEPTH    = 4,
  parameter int PC_W     = 32,
  parameter int MISP_GAP = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            c0_valid,
  input  logic [PC_W-1:0] c0_pc,
  input  logic            c0_taken,
  input  logic [PC_W-1:0] c0_target,
  input  logic            c0_misp,
  input  logic            c1_valid,
  input  logic [PC_W-1:0] c1_pc,
  input  logic            c1_taken,
  input  logic [PC_W-1:0] c1_target,
  input  logic            c1_misp,
  output logic            commit_ready,
  output logic            branch_commit,
  output logic [PC_W-1:0] pc_head,
  output logic            direct_resolved,
  output logic [PC_W-1:0] pc_resolved,
  output logic            direct_mispredict,
  output logic            drop_err
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int GAP_W = (MISP_GAP > 0) ? $clog2(MISP_GAP + 1) : 1;

  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] TWO_C    = CNT_W'(2);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [GAP_W-1:0] GAP_ZERO = {GAP_W{1'b0}};
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
  localparam logic [GAP_W-1:0] GAP_INIT = GAP_W'(MISP_GAP);

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic            taken;
    logic [PC_W-1:0] target;
    logic            misp;
  } entry_t;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_GAP  = 1'b1
  } state_t;

  // Storage and bookkeeping
  entry_t            mem_r [DEPTH];
  logic [CNT_W-1:0]  count_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [PTR_W-1:0]  wr_ptr_r;
  logic              commit_ready_r;
  logic              drop_err_r;

  // Issue state
  state_t            state_r;
  logic [GAP_W-1:0]  gap_cnt_r;
  logic              branch_commit_r;
  logic [PC_W-1:0]   pc_head_r;
  logic              direct_resolved_r;
  logic [PC_W-1:0]   pc_resolved_r;
  logic              direct_mispredict_r;

  // Next-state helpers
  logic              wr0_s;
  logic              wr1_s;
  logic              drop_s;
  logic [PTR_W-1:0]  wr_slot1_s;
  logic [CNT_W-1:0]  n_enq_s;
  logic              deq_s;
  logic [CNT_W-1:0]  count_nxt_s;
  logic              ready_nxt_s;
  entry_t            head_s;
  entry_t            c0_ent_s;
  entry_t            c1_ent_s;

  // Accept/drop decision per lane; a lane-0 mispredict squashes lane 1.
  always_comb begin
    wr0_s  = 1'b0;
    wr1_s  = 1'b0;
    drop_s = 1'b0;
    if (commit_ready_r) begin
      wr0_s = c0_valid;
      wr1_s = c1_valid & ~(c0_valid & c0_misp);
    end else begin
      drop_s = c0_valid | c1_valid;
    end
  end

  // Entry packing, slot selection and occupancy arithmetic.
  always_comb begin
    c0_ent_s    = '{pc: c0_pc, taken: c0_taken, target: c0_target, misp: c0_misp};
    c1_ent_s    = '{pc: c1_pc, taken: c1_taken, target: c1_target, misp: c1_misp};
    head_s      = mem_r[rd_ptr_r];
    if (wr0_s) begin
      wr_slot1_s = wr_ptr_r + PTR_ONE;
    end else begin
      wr_slot1_s = wr_ptr_r;
    end
    n_enq_s     = CNT_W'(wr0_s) + CNT_W'(wr1_s);
    deq_s       = (state_r == ST_IDLE) && (count_r != CNT_ZERO);
    count_nxt_s = count_r + n_enq_s - CNT_W'(deq_s);
    ready_nxt_s = ((DEPTH_C - count_nxt_s) >= TWO_C);
  end

  // FIFO payload writes: lane 0 first, lane 1 packed right behind it.
  always_ff @(posedge clk) begin
    if (wr0_s) begin
      mem_r[wr_ptr_r] <= c0_ent_s;
    end
    if (wr1_s) begin
      mem_r[wr_slot1_s] <= c1_ent_s;
    end
  end

  // FIFO pointers, occupancy, accept flag and sticky drop error.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r        <= CNT_ZERO;
      rd_ptr_r       <= PTR_ZERO;
      wr_ptr_r       <= PTR_ZERO;
      commit_ready_r <= 1'b1;
      drop_err_r     <= 1'b0;
    end else begin
      count_r        <= count_nxt_s;
      wr_ptr_r       <= wr_ptr_r + PTR_W'(n_enq_s);
      rd_ptr_r       <= rd_ptr_r + PTR_W'(deq_s);
      commit_ready_r <= ready_nxt_s;
      drop_err_r     <= drop_err_r | drop_s;
    end
  end

  // Issue FSM: pop one entry per cycle, then idle MISP_GAP cycles after a mispredict.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r             <= ST_IDLE;
      gap_cnt_r           <= GAP_ZERO;
      branch_commit_r     <= 1'b0;
      pc_head_r           <= {PC_W{1'b0}};
      direct_resolved_r   <= 1'b0;
      pc_resolved_r       <= {PC_W{1'b0}};
      direct_mispredict_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (deq_s) begin
            branch_commit_r     <= 1'b1;
            pc_head_r           <= head_s.pc;
            direct_resolved_r   <= head_s.taken;
            pc_resolved_r       <= head_s.target;
            direct_mispredict_r <= head_s.misp;
            if (head_s.misp && (MISP_GAP > 0)) begin
              state_r   <= ST_GAP;
              gap_cnt_r <= GAP_INIT;
            end else begin
              state_r   <= ST_IDLE;
              gap_cnt_r <= GAP_ZERO;
            end
          end else begin
            branch_commit_r     <= 1'b0;
            direct_mispredict_r <= 1'b0;
          end
        end
        ST_GAP: begin
          branch_commit_r     <= 1'b0;
          direct_mispredict_r <= 1'b0;
          if (gap_cnt_r <= GAP_ONE) begin
            state_r   <= ST_IDLE;
            gap_cnt_r <= GAP_ZERO;
          end else begin
            state_r   <= ST_GAP;
            gap_cnt_r <= gap_cnt_r - GAP_ONE;
          end
        end
        default: begin
          state_r             <= ST_IDLE;
          gap_cnt_r           <= GAP_ZERO;
          branch_commit_r     <= 1'b0;
          direct_mispredict_r <= 1'b0;
        end
      endcase
    end
  end

  assign commit_ready      = commit_ready_r;
  assign branch_commit     = branch_commit_r;
  assign pc_head           = pc_head_r;
  assign direct_resolved   = direct_resolved_r;
  assign pc_resolved       = pc_resolved_r;
  assign direct_mispredict = direct_mispredict_r;
  assign drop_err          = drop_err_r;

endmodule

// File: tb/tb_bp_update_sched.sv
// Directed bench for bp_update_sched (DEPTH=4, PC_W=32, MISP_GAP=2).
module tb_bp_update_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        c0_valid, c0_taken, c0_misp;
  logic [31:0] c0_pc, c0_target;
  logic        c1_valid, c1_taken, c1_misp;
  logic [31:0] c1_pc, c1_target;
  logic        commit_ready, branch_commit, direct_resolved, direct_mispredict, drop_err;
  logic [31:0] pc_head, pc_resolved;

  int n_cmp = 0;
  int n_bad = 0;

  bp_update_sched #(.DEPTH(4), .PC_W(32), .MISP_GAP(2)) dut (
    .clk(clk), .rst(rst),
    .c0_valid(c0_valid), .c0_pc(c0_pc), .c0_taken(c0_taken), .c0_target(c0_target), .c0_misp(c0_misp),
    .c1_valid(c1_valid), .c1_pc(c1_pc), .c1_taken(c1_taken), .c1_target(c1_target), .c1_misp(c1_misp),
    .commit_ready(commit_ready), .branch_commit(branch_commit), .pc_head(pc_head),
    .direct_resolved(direct_resolved), .pc_resolved(pc_resolved),
    .direct_mispredict(direct_mispredict), .drop_err(drop_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_c0(input logic [31:0] pc, input logic tk, input logic [31:0] tg, input logic mp);
    c0_valid = 1'b1; c0_pc = pc; c0_taken = tk; c0_target = tg; c0_misp = mp;
  endtask

  task automatic set_c1(input logic [31:0] pc, input logic tk, input logic [31:0] tg, input logic mp);
    c1_valid = 1'b1; c1_pc = pc; c1_taken = tk; c1_target = tg; c1_misp = mp;
  endtask

  task automatic clr();
    c0_valid = 1'b0; c0_pc = 32'h0; c0_taken = 1'b0; c0_target = 32'h0; c0_misp = 1'b0;
    c1_valid = 1'b0; c1_pc = 32'h0; c1_taken = 1'b0; c1_target = 32'h0; c1_misp = 1'b0;
  endtask

  // Two non-mispredicted commits: pc and pc+4, target = pc + 0x1000.
  task automatic dual(input logic [31:0] pc);
    set_c0(pc, 1'b1, pc + 32'h1000, 1'b0);
    set_c1(pc + 32'h4, 1'b1, pc + 32'h1004, 1'b0);
  endtask

  task automatic issue_chk(input string tag, input logic [31:0] pc);
    chk({tag, "_bc"}, 64'(branch_commit), 64'd1);
    chk({tag, "_pc"}, 64'(pc_head), 64'(pc));
  endtask

  initial begin
    rst = 1'b1;
    clr();
    step();
    step();
    // Reset state
    chk("rst_bc", 64'(branch_commit), 64'd0);
    chk("rst_ready", 64'(commit_ready), 64'd1);
    chk("rst_drop", 64'(drop_err), 64'd0);
    chk("rst_pc", 64'(pc_head), 64'd0);
    chk("rst_dm", 64'(direct_mispredict), 64'd0);
    rst = 1'b0;
    step();

    // Single commit
    set_c0(32'h100, 1'b1, 32'h200, 1'b0);
    step(); clr();
    chk("single_nobypass", 64'(branch_commit), 64'd0);
    step();
    issue_chk("single", 32'h100);
    chk("single_tgt", 64'(pc_resolved), 64'h200);
    chk("single_dir", 64'(direct_resolved), 64'd1);
    chk("single_dm", 64'(direct_mispredict), 64'd0);
    step();
    chk("single_off", 64'(branch_commit), 64'd0);
    chk("single_hold", 64'(pc_head), 64'h100);

    // Dual commit
    set_c0(32'h10, 1'b0, 32'h20, 1'b0);
    set_c1(32'h14, 1'b1, 32'h80, 1'b0);
    step(); clr();
    chk("dual_nobypass", 64'(branch_commit), 64'd0);
    step();
    issue_chk("dual0", 32'h10);
    chk("dual0_dir", 64'(direct_resolved), 64'd0);
    step();
    issue_chk("dual1", 32'h14);
    chk("dual1_tgt", 64'(pc_resolved), 64'h80);
    chk("dual1_dir", 64'(direct_resolved), 64'd1);
    step();
    chk("dual_empty", 64'(branch_commit), 64'd0);
    chk("dual_ready", 64'(commit_ready), 64'd1);

    // Mispredict gap
    set_c0(32'h40, 1'b1, 32'h400, 1'b1);
    step(); clr();
    set_c1(32'h44, 1'b0, 32'h48, 1'b0);
    step(); clr();
    issue_chk("misp", 32'h40);
    chk("misp_dm", 64'(direct_mispredict), 64'd1);
    step();
    chk("gap1_bc", 64'(branch_commit), 64'd0);
    chk("gap1_dm", 64'(direct_mispredict), 64'd0);
    chk("gap1_hold", 64'(pc_head), 64'h40);
    step();
    chk("gap2_bc", 64'(branch_commit), 64'd0);
    step();
    issue_chk("after_gap", 32'h44);
    chk("after_gap_dm", 64'(direct_mispredict), 64'd0);
    step();
    chk("after_gap_off", 64'(branch_commit), 64'd0);

    // Lane squash
    set_c0(32'h60, 1'b1, 32'h64, 1'b1);
    set_c1(32'h70, 1'b1, 32'h74, 1'b0);
    step(); clr();
    step();
    issue_chk("squash", 32'h60);
    chk("squash_drop", 64'(drop_err), 64'd0);
    step();
    step();
    step();
    chk("squash_none", 64'(branch_commit), 64'd0);
    chk("squash_ready", 64'(commit_ready), 64'd1);

    // Full / drop / pointer wrap over ten entries
    dual(32'hA00);
    step(); clr();
    chk("fill_ready2", 64'(commit_ready), 64'd1);
    dual(32'hA08);
    step(); clr();
    issue_chk("w0", 32'hA00);
    chk("full_ready3", 64'(commit_ready), 64'd0);
    set_c0(32'hDEAD, 1'b0, 32'hBEEF, 1'b0);
    step(); clr();
    chk("drop_set", 64'(drop_err), 64'd1);
    issue_chk("w1", 32'hA04);
    chk("ready_again", 64'(commit_ready), 64'd1);
    dual(32'hA10);
    step(); clr();
    issue_chk("w2", 32'hA08);
    chk("ready_low", 64'(commit_ready), 64'd0);
    step();
    issue_chk("w3", 32'hA0C);
    dual(32'hA18);
    step(); clr();
    issue_chk("w4", 32'hA10);
    step();
    issue_chk("w5", 32'hA14);
    dual(32'hA20);
    step(); clr();
    issue_chk("w6", 32'hA18);
    step();
    issue_chk("w7", 32'hA1C);
    step();
    issue_chk("w8", 32'hA20);
    step();
    issue_chk("w9", 32'hA24);
    step();
    chk("wrap_empty", 64'(branch_commit), 64'd0);
    chk("drop_sticky", 64'(drop_err), 64'd1);
    chk("wrap_ready", 64'(commit_ready), 64'd1);

    // Reset mid-drain with three buffered entries
    dual(32'hB00);
    step(); clr();
    dual(32'hB08);
    step(); clr();
    issue_chk("pre_rst", 32'hB00);
    chk("pre_rst_ready", 64'(commit_ready), 64'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_bc", 64'(branch_commit), 64'd0);
    chk("mid_rst_ready", 64'(commit_ready), 64'd1);
    chk("mid_rst_drop", 64'(drop_err), 64'd0);
    chk("mid_rst_pc", 64'(pc_head), 64'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("post_rst_idle", 64'(branch_commit), 64'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
